// File: rtl/iter_mul_unit.sv
// Iterative RV M-extension multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Consumes RADIX_BITS multiplier bits per BUSY cycle over a 2*XLEN accumulator,
// then applies the sign fix and selects the result half in a single FIX cycle.
module iter_mul_unit #(
   parameter int XLEN       = 64,
   parameter int RADIX_BITS = 4,
   parameter int TAG_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic             in_word,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int PW      = 2 * XLEN;
   localparam int NX      = XLEN / RADIX_BITS;
   localparam int NW      = 32 / RADIX_BITS;
   localparam int CW      = $clog2(NX + 1);
   localparam int SW      = $clog2(PW);
   localparam bit WORD_OK = (XLEN == 64);

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

   typedef struct packed {
      logic [1:0]       op;
      logic             word;
      logic             neg;
      logic [TAG_W-1:0] tag;
   } ctl_t;

   state_t          state;
   ctl_t            ctl;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_rem;
   logic [PW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   shamt;

   logic            word_req, a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_src, b_src, a_abs, b_abs;

   // Request decode: pick signedness per op and convert signed operands to magnitudes.
   // Negating in XLEN unsigned bits keeps |-2^(XLEN-1)| exact.
   always_comb begin
      word_req = in_word && WORD_OK;
      a_sgn    = !word_req && (in_op == 2'b01 || in_op == 2'b10);
      b_sgn    = !word_req && (in_op == 2'b01);
      a_src    = word_req ? XLEN'(in_a[31:0]) : in_a;
      b_src    = word_req ? XLEN'(in_b[31:0]) : in_b;
      a_neg    = a_sgn && in_a[XLEN-1];
      b_neg    = b_sgn && in_b[XLEN-1];
      a_abs    = a_neg ? -a_src : a_src;
      b_abs    = b_neg ? -b_src : b_src;
   end

   logic [XLEN+RADIX_BITS-1:0] pp;
   logic [PW-1:0]              pp_sh, p;
   logic [CW-1:0]              last;
   logic [XLEN-1:0]            res;

   // Datapath: one radix digit partial product per cycle, plus the final sign fix / half select.
   always_comb begin
      pp    = {{RADIX_BITS{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_rem[RADIX_BITS-1:0]};
      pp_sh = PW'(pp) << shamt;
      last  = ctl.word ? CW'(NW - 1) : CW'(NX - 1);
      p     = ctl.neg ? -acc : acc;
      if (ctl.word)             res = XLEN'($signed(p[31:0]));
      else if (ctl.op == 2'b00) res = p[XLEN-1:0];
      else                      res = p[PW-1:XLEN];
   end

   // Flush blocks acceptance in the same cycle so a killed request is never latched.
   assign in_ready = (state == IDLE) && !flush;

   // Control FSM and datapath registers; flush returns to IDLE from any state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ctl        <= '0;
         a_mag      <= '0;
         b_rem      <= '0;
         acc        <= '0;
         cnt        <= '0;
         shamt      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_mag    <= a_abs;
               b_rem    <= b_abs;
               ctl.op   <= in_op;
               ctl.word <= word_req;
               ctl.neg  <= a_neg ^ b_neg;
               ctl.tag  <= in_tag;
               acc      <= '0;
               cnt      <= '0;
               shamt    <= '0;
               state    <= BUSY;
            end
            BUSY: begin
               acc   <= acc + pp_sh;
               b_rem <= b_rem >> RADIX_BITS;
               cnt   <= cnt + 1'b1;
               shamt <= shamt + SW'(RADIX_BITS);
               if (cnt == last) state <= FIX;
            end
            FIX: begin
               out_result <= res;
               out_tag    <= ctl.tag;
               out_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_mul_unit.sv
// Scoreboard bench for iter_mul_unit (XLEN=64, RADIX_BITS=4): directed spec vectors,
// backpressure, flush, mid-op reset, then randomized ops against a 128-bit arithmetic model.
module tb_iter_mul_unit;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_word, out_valid, out_ready;
   logic [1:0]  in_op;
   logic [63:0] in_a, in_b, out_result;
   logic [4:0]  in_tag, out_tag;

   iter_mul_unit #(.XLEN(64), .RADIX_BITS(4), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
      int          acc_cyc;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   rand_rdy = 1'b0;

   localparam logic [63:0] A = 64'hFF22334455667788;
   localparam logic [63:0] B = 64'h00000000AABB0077;
   localparam logic [63:0] C = 64'h0000000087654321;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: full-width signed/unsigned product by plain 128-bit arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic word,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [127:0] ea, eb, p;
      logic [63:0]  w;
      if (word) begin
         w = {32'b0, a[31:0]} * {32'b0, b[31:0]};
         return {{32{w[31]}}, w[31:0]};
      end
      ea = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
      eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[63:0] : p[127:64];
   endfunction

   // Issue one request; the expected response goes into the scoreboard at the handshake.
   task automatic do_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input logic [4:0] tag);
      exp_t e;
      bit   acc = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = op; in_word = word; in_a = a; in_b = b; in_tag = tag;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.res = exp; e.tag = tag; e.acc_cyc = cyc; e.lat = word ? 10 : 18;
            q.push_back(e);
            acc = 1'b1;
         end
      end
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   // Monitor: compares every presented output against the scoreboard head.
   bit prev_v = 1'b0, prev_hs = 1'b0, prev_fl = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0; prev_hs = 1'b0; prev_fl = 1'b0;
      end else begin
         if (prev_hs && !flush) chk("in_ready_after_hs", 64'(in_ready), 64'd1);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               if (!prev_v) chk("latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
               chk("result", out_result, q[0].res);
               chk("tag", 64'(out_tag), 64'(q[0].tag));
               chk("in_ready_in_done", 64'(in_ready), 64'd0);
               if (out_ready) void'(q.pop_front());
            end
         end else if (prev_v && !prev_hs && !prev_fl) begin
            chk("out_valid_dropped", 64'(out_valid), 64'd1);
         end
         prev_v  = out_valid;
         prev_hs = out_valid && out_ready;
         prev_fl = flush;
      end
   end

   // Random consumer backpressure when enabled.
   initial forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 64'h0;
         1:       return 64'hFFFFFFFFFFFFFFFF;
         2:       return 64'h8000000000000000;
         3:       return 64'h7FFFFFFFFFFFFFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [63:0] ra, rb;
      logic [1:0]  rop;
      logic        rw;
      bit          seen;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
      in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      rst = 1'b0;

      // Directed vectors
      do_op(2'b00, 1'b0, A, B, 64'h6C8641FD52F99038, 5'd1);
      do_op(2'b01, 1'b0, A, B, 64'hFFFFFFFFFF6C1406, 5'd2);
      do_op(2'b11, 1'b0, A, B, 64'h00000000AA27147D, 5'd3);
      do_op(2'b10, 1'b0, A, B, 64'hFFFFFFFFFF6C1406, 5'd4);
      do_op(2'b10, 1'b0, B, A, 64'h00000000AA27147D, 5'd5);
      do_op(2'b01, 1'b0, A, A, 64'h0000C02B1FC02E8C, 5'd6);
      do_op(2'b00, 1'b1, A, B, 64'h0000000052F99038, 5'd7);
      do_op(2'b11, 1'b1, A, C, 64'hFFFFFFFFB4260088, 5'd8);
      do_op(2'b01, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 5'd9);
      do_op(2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 5'd10);
      do_op(2'b00, 1'b0, A, 64'h0, 64'h0, 5'd11);
      drain();

      // Backpressure: result held for 5 cycles in DONE
      @(posedge clk); #1 out_ready = 1'b0;
      do_op(2'b00, 1'b0, A, C, model(2'b00, 1'b0, A, C), 5'd12);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      chk("bp_out_valid_seen", 64'(seen), 64'd1);
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // Flush at BUSY cycle 3
      do_op(2'b01, 1'b0, A, B, 64'hFFFFFFFFFF6C1406, 5'd13);
      repeat (3) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1 flush = 1'b0;
      q.delete();
      @(negedge clk);
      chk("post_flush_in_ready", 64'(in_ready), 64'd1);
      chk("post_flush_out_valid", 64'(out_valid), 64'd0);
      repeat (25) @(posedge clk);
      do_op(2'b00, 1'b0, A, B, 64'h6C8641FD52F99038, 5'd14);
      drain();

      // Flush together with in_valid in IDLE: request must be refused
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = A; in_b = B; in_tag = 5'd15;
      #1 chk("flush_idle_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      repeat (25) @(posedge clk);

      // Reset asserted mid-BUSY
      do_op(2'b11, 1'b0, A, B, 64'h00000000AA27147D, 5'd16);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_result", out_result, 64'd0);
      chk("midrst_out_tag", 64'(out_tag), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      @(posedge clk); #1 rst = 1'b0;
      repeat (25) @(posedge clk);
      do_op(2'b00, 1'b1, A, C, model(2'b00, 1'b1, A, C), 5'd17);
      drain();

      // Randomized ops with random consumer backpressure
      rand_rdy = 1'b1;
      for (int n = 0; n < 60; n++) begin
         ra  = rand_operand();
         rb  = rand_operand();
         rop = 2'($urandom_range(0, 3));
         rw  = ($urandom_range(0, 3) == 0);
         do_op(rop, rw, ra, rb, model(rop, rw, ra, rb), 5'($urandom_range(0, 31)));
      end
      drain();
      rand_rdy = 1'b0;
      @(posedge clk); #1 out_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
